// File: rtl/fwrisc_dbus_uart.sv
// fwrisc_dbus_uart: fwrisc data-bus slave with DATA/STATUS/DIV regs and an
// 8N1 UART (TX FIFO + TX FSM). Ports: clock, reset, daddr/dvalid/dwrite/
// dwdata/dstrb -> dready/drdata, tx out, rx in. Receiver: FWRISC_UART_RX_EN.
module fwrisc_dbus_uart #(
  parameter int          TX_FIFO_DEPTH = 4,
  parameter logic [15:0] DEFAULT_DIV   = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic        dvalid,
  input  logic        dwrite,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dstrb,
  output logic        dready,
  output logic [31:0] drdata,
  output logic        tx,
  input  logic        rx
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_state_t;

  logic [15:0] div;
  logic [1:0]  sel;
  logic        accept;
  logic        is_data_st;
  logic        push;
  logic        pop;
  logic [31:0] rdata_n;

  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;

  tx_state_t   tx_state;
  tx_state_t   tx_state_n;
  logic [15:0] baud_cnt;
  logic [15:0] baud_n;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_n;
  logic [7:0]  tx_sh;
  logic [7:0]  sh_n;
  logic        tx_n;
  logic        tx_busy;

  logic        rx_valid;
  logic        rx_ovr;
  logic        rx_ferr;
  logic [7:0]  rx_byte;

  logic        bus_unused;
  assign bus_unused = ^{daddr[31:4], daddr[1:0],
                        dwdata[31:16], dstrb[3:2]};

  assign sel        = daddr[3:2];
  assign is_data_st = dwrite && (sel == 2'd0);
  // A DATA store into a full FIFO is held off until an entry frees.
  assign accept     = dvalid && !dready &&
                      !(is_data_st && fifo_full);
  assign push       = accept && is_data_st && dstrb[0];

  // Extra pointer bit separates full from empty after wrap.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_busy    = (tx_state != T_IDLE);

  always_comb begin
    rdata_n = '0;
    unique case (sel)
      2'd0: rdata_n = {rx_valid, 23'd0, rx_byte};
      2'd1: rdata_n = {26'd0, rx_ferr, rx_ovr, rx_valid,
                       tx_busy, fifo_empty, fifo_full};
      2'd2: rdata_n = {16'd0, div};
      default: rdata_n = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dready <= 1'b0;
      drdata <= '0;
      div    <= DEFAULT_DIV;
    end else begin
      dready <= accept;
      drdata <= (accept && !dwrite) ? rdata_n : '0;
      if (accept && dwrite && sel == 2'd2) begin
        if (dstrb[0]) div[7:0]  <= dwdata[7:0];
        if (dstrb[1]) div[15:8] <= dwdata[15:8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= dwdata[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= T_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      tx_sh    <= sh_n;
      tx       <= tx_n;
    end
  end

  // Baud counter reloads with div on every state/bit change, so a
  // DIV write mid-frame applies from the next reload.
  always_comb begin
    tx_state_n = tx_state;
    baud_n     = baud_cnt - 16'd1;
    bit_n      = bit_cnt;
    sh_n       = tx_sh;
    pop        = 1'b0;
    tx_n       = 1'b1;
    unique case (tx_state)
      T_IDLE: begin
        baud_n = baud_cnt;
        if (!fifo_empty) begin
          tx_state_n = T_START;
          pop        = 1'b1;
          sh_n       = fifo_mem[rd_ptr[AW-1:0]];
          baud_n     = div;
        end
      end
      T_START: begin
        if (baud_cnt == 16'd0) begin
          tx_state_n = T_DATA;
          bit_n      = 3'd0;
          baud_n     = div;
        end
      end
      T_DATA: begin
        if (baud_cnt == 16'd0) begin
          baud_n = div;
          bit_n  = bit_cnt + 3'd1;
          sh_n   = tx_sh >> 1;
          if (bit_cnt == 3'd7) tx_state_n = T_STOP;
        end
      end
      T_STOP: begin
        if (baud_cnt == 16'd0) begin
          baud_n = div;
          if (!fifo_empty) begin
            tx_state_n = T_START;
            pop        = 1'b1;
            sh_n       = fifo_mem[rd_ptr[AW-1:0]];
          end else begin
            tx_state_n = T_IDLE;
          end
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
    if (tx_state_n == T_START) tx_n = 1'b0;
    else if (tx_state_n == T_DATA) tx_n = sh_n[0];
  end

`ifdef FWRISC_UART_RX_EN
  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  rx_state_t   rx_state;
  rx_state_t   rx_state_n;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [15:0] rx_cnt;
  logic [15:0] rx_cnt_n;
  logic [2:0]  rx_bit;
  logic [2:0]  rx_bit_n;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_sh_n;
  logic        rx_done;
  logic [15:0] rx_half;
  logic        rd_data;
  logic        rd_stat;

  assign rd_data = accept && !dwrite && (sel == 2'd0);
  assign rd_stat = accept && !dwrite && (sel == 2'd1);
  assign rx_half = div >> 1;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt - 16'd1;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_done    = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        rx_cnt_n = rx_cnt;
        if (rx_prev && !rx_s2) begin
          rx_state_n = R_START;
          // edge detect costs one cycle; land mid start bit
          rx_cnt_n = (rx_half == 16'd0) ? 16'd0
                                        : rx_half - 16'd1;
        end
      end
      R_START: begin
        if (rx_cnt == 16'd0) begin
          rx_cnt_n   = div;
          rx_bit_n   = 3'd0;
          rx_state_n = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_cnt_n = div;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt == 16'd0) begin
          rx_done    = 1'b1;
          rx_state_n = R_IDLE;
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      if (rd_stat) begin
        rx_ovr  <= 1'b0;
        rx_ferr <= 1'b0;
      end
      // a completing byte beats a same-cycle clear
      if (rx_done) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
        if (rx_valid) rx_ovr  <= 1'b1;
        if (!rx_s2)   rx_ferr <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
    end
  end
`else
  logic rx_unused;
  assign rx_unused = rx;
  assign rx_valid  = 1'b0;
  assign rx_ovr    = 1'b0;
  assign rx_ferr   = 1'b0;
  assign rx_byte   = 8'd0;
`endif

endmodule

// File: tb/tb_fwrisc_dbus_uart.sv
// tb_fwrisc_dbus_uart: randomized bench for fwrisc_dbus_uart with a
// behavioural UART line model and register model.
module tb_fwrisc_dbus_uart;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic        dvalid;
  logic        dwrite;
  logic [31:0] dwdata;
  logic [3:0]  dstrb;
  logic        dready;
  logic [31:0] drdata;
  logic        tx;
  logic        rx;

  int n_chk = 0;
  int n_err = 0;
  int cur_div = 433;

  fwrisc_dbus_uart #(
    .TX_FIFO_DEPTH(4),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clock (clock),
    .reset (reset),
    .daddr (daddr),
    .dvalid(dvalid),
    .dwrite(dwrite),
    .dwdata(dwdata),
    .dstrb (dstrb),
    .dready(dready),
    .drdata(drdata),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge where dready is seen.
  task automatic bus(input logic [1:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int lat);
    daddr  = {28'd0, a, 2'd0};
    dwrite = w;
    dwdata = d;
    dstrb  = s;
    dvalid = 1'b1;
    lat    = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!dready && lat < 4000);
    if (!dready) chk("bus_timeout", 32'(dready), 32'd1);
    rd     = drdata;
    dvalid = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a,
                        output logic [31:0] v);
    int l;
    bus(a, 1'b0, 32'd0, 4'b1111, v, l);
  endtask

  task automatic wr_reg(input logic [1:0] a,
                        input logic [31:0] d,
                        input logic [3:0] s);
    logic [31:0] v;
    int l;
    bus(a, 1'b1, d, s, v, l);
    chk("st_rdata", v, 32'd0);
  endtask

  task automatic set_div(input int dv);
    cur_div = dv;
    wr_reg(2'd2, 32'(dv), 4'b0011);
  endtask

  // Line-level UART receive of one TX frame.
  task automatic tx_get_byte(output logic [7:0] b,
                             output int gap);
    int h;
    h   = (cur_div + 1) / 2;
    gap = 0;
    b   = 8'd0;
    while (tx !== 1'b0 && gap < 20000) begin
      @(negedge clock);
      gap++;
    end
    chk("tx_start_seen", 32'(tx), 32'd0);
    repeat (h) @(negedge clock);
    chk("tx_start_mid", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (cur_div + 1) @(negedge clock);
      b[i] = tx;
    end
    repeat (cur_div + 1) @(negedge clock);
    chk("tx_stop", 32'(tx), 32'd1);
  endtask

  task automatic drive_rx(input logic [7:0] b,
                          input logic stopv);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (cur_div + 1) @(negedge clock);
    end
    rx = 1'b1;
    repeat (2 * (cur_div + 1)) @(negedge clock);
  endtask

  task automatic count_tx_low(input int n, output int z);
    z = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (tx === 1'b0) z++;
    end
  endtask

  logic [31:0] v;
  logic [15:0] dm;
  logic [7:0]  b;
  logic [7:0]  rb;
  logic [3:0]  s;
  logic [39:0] wave;
  logic [39:0] wexp;
  logic [9:0]  fr;
  logic [7:0]  exp_b [8];
  int          n_exp;
  int          lat;
  int          maxlat;
  int          gap;
  int          z;

  initial begin
    reset  = 1'b1;
    daddr  = '0;
    dvalid = 1'b0;
    dwrite = 1'b0;
    dwdata = '0;
    dstrb  = '0;
    rx     = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_dready", 32'(dready), 32'd0);
    chk("rst_drdata", drdata, 32'd0);
    reset = 1'b0;

    bus(2'd1, 1'b0, 32'd0, 4'hf, v, lat);
    chk("status_rst", v, 32'h2);
    chk("status_lat", 32'(lat), 32'd1);
    @(negedge clock);
    chk("dready_pulse", 32'(dready), 32'd0);
    chk("idle_drdata", drdata, 32'd0);

    rd_reg(2'd2, v);
    chk("div_rst", v, 32'd433);
    wr_reg(2'd2, 32'h0000_0007, 4'b0001);
    rd_reg(2'd2, v);
    chk("div_lane0", v, 32'h0000_0107);
    wr_reg(2'd3, 32'hdead_beef, 4'hf);
    rd_reg(2'd3, v);
    chk("reg3_zero", v, 32'd0);

    dm = 16'h0107;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      s = 4'($urandom);
      wr_reg(2'd2, v, s);
      if (s[0]) dm[7:0]  = v[7:0];
      if (s[1]) dm[15:8] = v[15:8];
      rd_reg(2'd2, v);
      chk("div_rand", v, {16'd0, dm});
    end

    // Exact waveform of one frame.
    set_div(3);
    wr_reg(2'd0, 32'ha5a5_a5a5, 4'b0001);
    fr = {1'b1, 8'ha5, 1'b0};
    for (int i = 0; i < 40; i++) wexp[i] = fr[i / 4];
    z = 0;
    while (tx !== 1'b0 && z < 100) begin
      @(negedge clock);
      z++;
    end
    for (int i = 0; i < 40; i++) begin
      wave[i] = tx;
      @(negedge clock);
    end
    chk("wave_lo", wave[31:0], wexp[31:0]);
    chk("wave_hi", 32'(wave[39:32]), 32'(wexp[39:32]));
    repeat (4) @(negedge clock);
    rd_reg(2'd1, v);
    chk("status_done", v, 32'h2);

    // Status mid-frame.
    b = 8'($urandom);
    wr_reg(2'd0, {4{b}}, 4'b0001);
    fork
      tx_get_byte(rb, gap);
      begin
        repeat (10) @(negedge clock);
        rd_reg(2'd1, v);
        chk("status_busy", v, 32'h6);
      end
    join
    chk("single_byte", 32'(rb), 32'(b));
    repeat (3) @(negedge clock);
    rd_reg(2'd1, v);
    chk("status_idle", v, 32'h2);

    // Burst: overfill the FIFO, one store without lane 0.
    n_exp = 0;
    fork
      begin
        logic [31:0] r1;
        int l1;
        logic [7:0] x;
        maxlat = 0;
        for (int i = 0; i < 7; i++) begin
          x = 8'($urandom);
          s = (i == 3) ? 4'b1110 : 4'b0001;
          bus(2'd0, 1'b1, {4{x}}, s, r1, l1);
          if (s[0]) begin
            exp_b[n_exp] = x;
            n_exp++;
          end
          if (l1 > maxlat) maxlat = l1;
        end
      end
      begin
        logic [7:0] y;
        int g;
        for (int k = 0; k < 6; k++) begin
          tx_get_byte(y, g);
          chk("burst_byte", 32'(y), 32'(exp_b[k]));
          if (k > 0) chk("burst_gap", 32'(g <= cur_div + 1), 32'd1);
        end
      end
    join
    chk("burst_npush", 32'(n_exp), 32'd6);
    chk("burst_stalled", 32'(maxlat > cur_div + 2), 32'd1);
    count_tx_low(60, z);
    chk("burst_no_extra", 32'(z), 32'd0);
    rd_reg(2'd1, v);
    chk("burst_status", v, 32'h2);

    // Random divisor, one byte.
    set_div($urandom_range(1, 6));
    b = 8'($urandom);
    wr_reg(2'd0, {4{b}}, 4'b0001);
    tx_get_byte(rb, gap);
    chk("rdiv_byte", 32'(rb), 32'(b));
    repeat (cur_div + 2) @(negedge clock);
    set_div(3);

    // Reset in the middle of a data bit.
    for (int i = 0; i < 3; i++) wr_reg(2'd0, $urandom, 4'b0001);
    z = 0;
    while (tx !== 1'b0 && z < 100) begin
      @(negedge clock);
      z++;
    end
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_dready", 32'(dready), 32'd0);
    reset   = 1'b0;
    cur_div = 433;
    rd_reg(2'd1, v);
    chk("midrst_status", v, 32'h2);
    rd_reg(2'd2, v);
    chk("midrst_div", v, 32'd433);
    count_tx_low(40, z);
    chk("midrst_quiet", 32'(z), 32'd0);
    set_div(3);
    b = 8'($urandom);
    wr_reg(2'd0, {4{b}}, 4'b0001);
    tx_get_byte(rb, gap);
    chk("post_rst_byte", 32'(rb), 32'(b));
    repeat (4) @(negedge clock);

`ifdef FWRISC_UART_RX_EN
    b = 8'($urandom);
    drive_rx(8'h3c, 1'b1);
    drive_rx(b, 1'b1);
    rd_reg(2'd1, v);
    chk("rx_ovr_status", v, 32'h1a);
    rd_reg(2'd1, v);
    chk("rx_ovr_clr", v, 32'h0a);
    rd_reg(2'd0, v);
    chk("rx_data2", v, {1'b1, 23'd0, b});
    rd_reg(2'd1, v);
    chk("rx_valid_clr", v, 32'h2);
    rd_reg(2'd0, v);
    chk("rx_data_old", v, {24'd0, b});
    b = 8'($urandom);
    drive_rx(b, 1'b0);
    rd_reg(2'd1, v);
    chk("rx_ferr", v, 32'h2a);
    rd_reg(2'd0, v);
    chk("rx_ferr_data", v, {1'b1, 23'd0, b});
    rd_reg(2'd1, v);
    chk("rx_ferr_clr", v, 32'h2);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (60) @(negedge clock);
    rd_reg(2'd1, v);
    chk("rx_glitch", v, 32'h2);
`else
    drive_rx(8'h3c, 1'b1);
    rd_reg(2'd1, v);
    chk("norx_status", v, 32'h2);
    rd_reg(2'd0, v);
    chk("norx_data", v, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
